axi_stream_master: RTL and testbench
====================================

// Module: axi_stream_master
// PURPOSE
//   Transmit-side counterpart of axi_stream_slave: serialises one measurement packet onto AXI-Stream.
//   Packet = 1 ID beat followed by PCK_SIZE payload beats; tlast is set on the final payload beat.
//   Sits between the frequency-measurement core (parallel result word) and the stream link to the receiver.
// PARAMETERS
//   PCK_SIZE  4      number of payload beats per packet (>=1)
//   DATA_W    8      tdata width in bits
//   ID        8'h7F  value driven on the first (header) beat; receiver accepts only 8'h7F
// PORTS
//   clk      in   1                  system clock, all logic on rising edge
//   rst_n    in   1                  asynchronous active-low reset
//   send     in   1                  request: latch payload and start a packet (honoured only when busy=0)
//   payload  in   PCK_SIZE*DATA_W    packet data; beat 0 = payload[PCK_SIZE*DATA_W-1 -: DATA_W] (MSB first)
//   busy     out  1                  1 from the cycle after send is accepted until the final handshake
//   done     out  1                  1-cycle pulse, cycle after the final (tlast) handshake
//   axi      -    axi_if.master      tvalid/tdata[DATA_W]/tlast driven out, tready sampled in
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, tvalid=0, tdata=0, tlast=0, busy=0, done=0, beat counter=0,
//     payload register=0. Reset mid-packet aborts immediately; tvalid falls asynchronously, no tlast sent.
//   Handshake: beat transfers on a rising edge with tvalid&&tready. While tvalid=1&&tready=0, tdata and tlast
//     hold stable; tvalid never deasserts before its beat transfers (AXI-Stream rule).
//   tvalid does not depend combinationally on tready; all outputs are registered.
//   FSM:
//     IDLE  : tvalid=0. send=1 -> latch payload, tdata<=ID, tvalid<=1, tlast<=0, cnt<=0 -> HDR.
//     HDR   : on handshake -> tdata<=beat 0, tlast<=(PCK_SIZE==1) -> DATA.
//     DATA  : on handshake with tlast=0 -> cnt<=cnt+1, tdata<=beat cnt+1, tlast<=(cnt+1==PCK_SIZE-1).
//             on handshake with tlast=1 -> tvalid<=0, tlast<=0, done<=1 -> IDLE.
//   Latency: send accepted at edge N -> ID beat valid after edge N; with tready held 1 the packet occupies
//     PCK_SIZE+1 consecutive cycles; done=1 in the cycle after the tlast beat.
//   Back-to-back: send high during the done cycle (state IDLE) is accepted; no other gap is inserted.
//   send while busy=1 is ignored (not queued); payload changes while busy do not affect the packet in flight.
//   tready=0 indefinitely: block waits holding the current beat; no timeout.
//   Beat counter width $clog2(PCK_SIZE+1); never exceeds PCK_SIZE-1 in DATA.
//   busy = (state != IDLE); done deasserts automatically after one cycle.
// TESTING
//   1. Reset 10 cycles, tready=1, send payload 32'hAABBCCDD -> tdata 7F,AA,BB,CC,DD on 5 consecutive
//      cycles, tlast only with DD, done pulse next cycle; axi_stream_slave as receiver sees valid packet.
//   2. tready toggling 1,0,0,1,0,1... during payload 32'h4521_4455 -> every beat held stable while tready=0,
//      sequence 7F,45,21,44,55 unchanged, no duplicate or dropped beat.
//   3. send asserted again during done cycle with 32'h11223344 -> second packet ID beat immediately follows,
//      no idle cycle; busy stays 0 for exactly the done cycle.
//   4. send pulsed and payload changed to 32'hFFFFFFFF while busy -> ignored; in-flight packet still
//      7F,AA,BB,CC,DD; no second packet.
//   5. rst_n=0 after 2nd payload beat -> tvalid/tlast/busy 0 immediately; after release, next send emits
//      complete fresh packet starting with 7F.
//   6. PCK_SIZE=1 build, payload 8'h5A -> beats 7F then 5A with tlast, done next cycle.

Source files
------------

// File: rtl/axi_stream_master_if.sv
// AXI-Stream link bundle: master drives tvalid/tdata/tlast, slave drives tready.
interface axi_if #(
    parameter int DATA_W = 8
) ();
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_stream_master.sv
// Serialises one measurement packet (ID header beat + PCK_SIZE payload beats,
// MSB-first) onto AXI-Stream. All stream outputs come straight from flops.
module axi_stream_master #(
    parameter int                PCK_SIZE = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] ID       = DATA_W'('h7F)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       send,
    input  logic [PCK_SIZE*DATA_W-1:0] payload,
    output logic                       busy,
    output logic                       done,
    axi_if.master                      axi
);
    localparam int PW = PCK_SIZE * DATA_W;
    localparam int CW = $clog2(PCK_SIZE + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     pay_q, pay_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              done_q, done_d;
    logic              hs;

    assign hs         = tvalid_q && axi.tready;
    assign axi.tvalid = tvalid_q;
    assign axi.tdata  = tdata_q;
    assign axi.tlast  = tlast_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pay_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pay_q    <= pay_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. The payload register shifts left one beat per
    // transfer so the next beat is always in its top DATA_W bits; without a
    // handshake every output holds, keeping the beat stable under backpressure.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pay_d    = pay_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (send) begin
                    pay_d    = payload;
                    tdata_d  = ID;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    tdata_d = pay_q[PW-1 -: DATA_W];
                    pay_d   = pay_q << DATA_W;
                    tlast_d = (PCK_SIZE == 1);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        tdata_d = pay_q[PW-1 -: DATA_W];
                        pay_d   = pay_q << DATA_W;
                        tlast_d = ((cnt_q + CW'(1)) == CW'(PCK_SIZE - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_stream_master.sv
// Directed bench for axi_stream_master: a PCK_SIZE=4 instance for the main
// scenarios plus a PCK_SIZE=1 instance for the single-beat build.
module tb_axi_stream_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [31:0] payload = '0;
    logic        busy, done;
    logic        send1 = 1'b0;
    logic [7:0]  payload1 = '0;
    logic        busy1, done1;
    int          checks = 0;
    int          failures = 0;

    axi_if #(.DATA_W(8)) axi0 ();
    axi_if #(.DATA_W(8)) axi1 ();

    axi_stream_master #(.PCK_SIZE(4), .DATA_W(8), .ID(8'h7F)) u_dut (
        .clk(clk), .rst_n(rst_n), .send(send), .payload(payload),
        .busy(busy), .done(done), .axi(axi0)
    );

    axi_stream_master #(.PCK_SIZE(1), .DATA_W(8), .ID(8'h7F)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .send(send1), .payload(payload1),
        .busy(busy1), .done(done1), .axi(axi1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Beat log for instance 0, plus hold-stable check while stalled.
    logic [8:0] beats[$];
    logic       stall = 1'b0;
    logic [9:0] held = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall)
                chk("hold", 32'({axi0.tvalid, axi0.tlast, axi0.tdata}), 32'(held));
            if (axi0.tvalid && axi0.tready)
                beats.push_back({axi0.tlast, axi0.tdata});
            stall = axi0.tvalid && !axi0.tready;
            held  = {axi0.tvalid, axi0.tlast, axi0.tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a packet; returns in the cycle the ID beat is first valid.
    task automatic send_pkt(input logic [31:0] p);
        send    = 1'b1;
        payload = p;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic check_pkt(input string tag, input logic [31:0] p);
        chk({tag, "_len"}, 32'(beats.size()), 5);
        for (int i = 0; i < 5 && i < beats.size(); i++) begin
            logic [8:0] e;
            e = (i == 0) ? {1'b0, 8'h7F} : {(i == 4), p[31 - 8*(i-1) -: 8]};
            chk(tag, 32'(beats[i]), 32'(e));
        end
    endtask

    initial begin
        logic [7:0]  exp1 [5];
        logic [11:0] pat;
        exp1 = '{8'h7F, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pat  = 12'b1011_0010_1001;   // bit 0 first: 1,0,0,1,0,1,0,0,1,1,0,1
        axi0.tready = 1'b1;
        axi1.tready = 1'b1;

        // Reset state
        repeat (10) tick();
        chk("rst_tvalid", 32'(axi0.tvalid), 0);
        chk("rst_tdata",  32'(axi0.tdata),  0);
        chk("rst_tlast",  32'(axi0.tlast),  0);
        chk("rst_busy",   32'(busy),        0);
        chk("rst_done",   32'(done),        0);
        chk("rst_tvalid1", 32'(axi1.tvalid), 0);
        rst_n = 1'b1;
        tick();

        // 1: basic packet, cycle-exact
        beats.delete();
        send_pkt(32'hAABBCCDD);
        for (int i = 0; i < 5; i++) begin
            chk("t1_tvalid", 32'(axi0.tvalid), 1);
            chk("t1_tdata",  32'(axi0.tdata),  32'(exp1[i]));
            chk("t1_tlast",  32'(axi0.tlast),  (i == 4) ? 1 : 0);
            chk("t1_busy",   32'(busy),        1);
            tick();
        end
        chk("t1_done",   32'(done),        1);
        chk("t1_vld_lo", 32'(axi0.tvalid), 0);
        chk("t1_busy_lo", 32'(busy),       0);
        tick();
        chk("t1_done_lo", 32'(done), 0);
        check_pkt("t1_pkt", 32'hAABBCCDD);

        // 2: backpressure with toggling tready
        beats.delete();
        send_pkt(32'h45214455);
        for (int i = 0; i < 40; i++) begin
            axi0.tready = pat[i % 12];
            tick();
            if (done) break;
        end
        chk("t2_done", 32'(done), 1);
        axi0.tready = 1'b1;
        check_pkt("t2_pkt", 32'h45214455);

        // 3: back-to-back, send in the done cycle
        tick();
        beats.delete();
        send_pkt(32'hAABBCCDD);
        wait_done(20);
        chk("t3_busy_gap", 32'(busy), 0);
        send_pkt(32'h11223344);
        chk("t3_id_next", 32'({axi0.tvalid, axi0.tdata}), 32'h17F);
        chk("t3_busy_hi", 32'(busy), 1);
        beats.delete();
        beats.push_back({1'b0, 8'h7F}); // popped below: keep queue for 2nd packet only
        beats.delete();
        wait_done(20);
        chk("t3_len_after", 32'(beats.size()), 5);
        if (beats.size() == 5)
            chk("t3_last", 32'(beats[4]), 32'h144);

        // 4: send + payload change while busy are ignored
        tick();
        beats.delete();
        send_pkt(32'hAABBCCDD);
        send = 1'b1;
        payload = 32'hFFFFFFFF;
        tick();
        send = 1'b0;
        wait_done(20);
        check_pkt("t4_pkt", 32'hAABBCCDD);
        beats.delete();
        repeat (6) tick();
        chk("t4_no_2nd", 32'(beats.size()), 0);
        chk("t4_idle", 32'(busy), 0);

        // 5: reset mid-packet, then a fresh packet
        send_pkt(32'hAABBCCDD);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_tvalid", 32'(axi0.tvalid), 0);
        chk("t5_tlast",  32'(axi0.tlast),  0);
        chk("t5_busy",   32'(busy),        0);
        tick();
        rst_n = 1'b1;
        tick();
        beats.delete();
        send_pkt(32'h11223344);
        wait_done(20);
        check_pkt("t5_pkt", 32'h11223344);

        // 6: single-beat build
        send1    = 1'b1;
        payload1 = 8'h5A;
        tick();
        send1 = 1'b0;
        chk("t6_id",   32'({axi1.tvalid, axi1.tlast, axi1.tdata}), 32'h27F);
        tick();
        chk("t6_data", 32'({axi1.tvalid, axi1.tlast, axi1.tdata}), 32'h35A);
        tick();
        chk("t6_done", 32'(done1), 1);
        chk("t6_vld_lo", 32'(axi1.tvalid), 0);
        tick();
        chk("t6_done_lo", 32'(done1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
